// File: rtl/test_pattern_gen.sv
// -----------------------------------------------------------------------------
// test_pattern_gen
//
// Clocked test-input source for the display path. Board switches are brought
// into the clock domain, then on every internal update tick a new frame of
// NUM_CH channel values is computed from one of four animated patterns
// (static, ramp, decay, walk) and offered to the display core over a
// valid/ready handshake.
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous, active-low reset
//   switches     - raw switches; [NUM_CH-1:0] channel enables,
//                  [NUM_CH+1:NUM_CH] pattern mode
//   output_array - registered frame, element i is channel i
//   frame_valid  - frame on output_array is new and not yet accepted
//   frame_ready  - consumer accepts the frame when high with frame_valid
//   overrun      - sticky: an update tick was dropped under backpressure
// -----------------------------------------------------------------------------
module test_pattern_gen #(
    parameter int                NUM_CH   = 16,
    parameter int                DATA_W   = 16,
    parameter int                NUM_SW   = 18,
    parameter int                TICK_DIV = 50000,
    parameter logic [DATA_W-1:0] STEP     = 16'h0100
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_SW-1:0]              switches,
    output logic [NUM_CH-1:0][DATA_W-1:0]  output_array,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           overrun
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int SYNC_W = NUM_CH + 2;
    // Ramp channels are spread evenly over the full code range.
    localparam int OFF_SH = DATA_W - CH_W;

    localparam logic [DATA_W-1:0] MAX_VAL  = '1;
    localparam logic [DATA_W-1:0] MID_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_RAMP   = 2'b01,
        MODE_DECAY  = 2'b10,
        MODE_WALK   = 2'b11
    } mode_t;

    // Unsigned subtraction that clamps at zero instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_sub(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return (a >= b) ? (a - b) : '0;
    endfunction

    // Fixed per-channel ramp offset: ch * 2^DATA_W / NUM_CH.
    function automatic logic [DATA_W-1:0] ch_offset(input int ch);
        return DATA_W'(ch) << OFF_SH;
    endfunction

    logic [SYNC_W-1:0]             sw_p0;
    logic [SYNC_W-1:0]             sw_p1;
    logic [NUM_CH-1:0]             en;
    mode_t                         mode;
    mode_t                         mode_prev;
    logic                          mode_change;

    logic [CNT_W-1:0]              tick_cnt;
    logic                          tick;

    logic [DATA_W-1:0]             phase;
    logic [CH_W-1:0]               walk_idx;
    logic [NUM_CH-1:0][DATA_W-1:0] next_frame;

    logic                          load;
    logic                          drop;
    logic                          xfer;

    // Switches above the enable and mode fields carry no meaning here.
    logic                          unused_sw;
    generate
        if (NUM_SW > SYNC_W) begin : g_spare_sw
            assign unused_sw = ^switches[NUM_SW-1:SYNC_W];
        end else begin : g_no_spare_sw
            assign unused_sw = 1'b0;
        end
    endgenerate

    assign en          = sw_p1[NUM_CH-1:0];
    assign mode        = mode_t'(sw_p1[NUM_CH+1:NUM_CH]);
    assign mode_change = (mode != mode_prev);

    assign tick = (tick_cnt == CNT_LAST);

    // A tick is taken when the output slot is free or is being emptied this
    // very cycle; otherwise it is dropped and the held frame is untouched.
    assign xfer = frame_valid & frame_ready;
    assign load = tick & (~frame_valid | frame_ready);
    assign drop = tick & frame_valid & ~frame_ready;

    // ---- pattern generation (combinational, from synced switches + state) --
    always_comb begin
        next_frame = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode)
                MODE_STATIC: next_frame[i] = en[i] ? MID_VAL : '0;
                MODE_RAMP:   next_frame[i] = en[i] ? (phase + ch_offset(i)) : '0;
                // Decay works on the frame currently held on the output.
                MODE_DECAY:  next_frame[i] = en[i] ? MAX_VAL
                                                   : sat_sub(output_array[i], STEP);
                MODE_WALK:   next_frame[i] = (en[i] && (walk_idx == CH_W'(i)))
                                             ? MAX_VAL : '0;
                default:     next_frame[i] = '0;
            endcase
        end
    end

    // ---- switch synchroniser and mode history ------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_p0     <= '0;
            sw_p1     <= '0;
            mode_prev <= MODE_STATIC;
        end else begin
            sw_p0     <= switches[SYNC_W-1:0];
            sw_p1     <= sw_p0;
            mode_prev <= mode;
        end
    end

    // ---- update tick divider -----------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // ---- pattern state: ramp phase and walk index --------------------------
    // A mode change restarts the animation; the frame loaded alongside it (if
    // any) still uses the state as it was.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            walk_idx <= '0;
        end else if (mode_change) begin
            phase    <= '0;
            walk_idx <= '0;
        end else if (load) begin
            if (mode == MODE_RAMP) begin
                phase <= phase + STEP;
            end
            // Index advances even onto disabled channels, giving dark frames.
            if (mode == MODE_WALK) begin
                walk_idx <= walk_idx + CH_W'(1);
            end
        end
    end

    // ---- output frame register and handshake -------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            output_array <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load) begin
                output_array <= next_frame;
                frame_valid  <= 1'b1;
            end else if (xfer) begin
                frame_valid  <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
module tb_test_pattern_gen;

    logic                  clk;
    logic                  reset_n;
    logic [17:0]           switches;
    logic                  frame_ready;

    logic [15:0][15:0]     out_a;
    logic                  fv_a;
    logic                  ov_a;
    logic [15:0][15:0]     out_d;
    logic                  fv_d;
    logic                  ov_d;

    logic [15:0][15:0]     exp_f;
    logic [15:0]           decay_seq [0:5];
    logic                  ok;

    int n_tests = 0;
    int n_fail  = 0;

    // Main instance: STEP 16'h0100 for static, ramp, walk and backpressure.
    test_pattern_gen #(
        .NUM_CH(16), .DATA_W(16), .NUM_SW(18), .TICK_DIV(4), .STEP(16'h0100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .switches(switches),
        .output_array(out_a), .frame_valid(fv_a), .frame_ready(frame_ready),
        .overrun(ov_a)
    );

    // Second instance with a coarse STEP for the decay sequence.
    test_pattern_gen #(
        .NUM_CH(16), .DATA_W(16), .NUM_SW(18), .TICK_DIV(4), .STEP(16'h4000)
    ) dut_d (
        .clk(clk), .reset_n(reset_n), .switches(switches),
        .output_array(out_d), .frame_valid(fv_d), .frame_ready(frame_ready),
        .overrun(ov_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input logic [17:0] sw);
        reset_n     = 1'b0;
        switches    = sw;
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n     = 1'b1;
    endtask

    // Advance to the next negedge where frame_valid is high; bounded.
    task automatic wait_frame(input bit use_d, output logic got);
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if ((use_d ? fv_d : fv_a) === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; switches = '0; frame_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_a !== '0) begin
            n_fail++; $display("FAIL reset_out: got %h expected 0", out_a);
        end
        n_tests++;
        if (fv_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", fv_a);
        end
        n_tests++;
        if (ov_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_overrun: got %b expected 0", ov_a);
        end
        n_tests++;
        if (out_d !== '0 || fv_d !== 1'b0 || ov_d !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut_d: got out=%h v=%b o=%b expected 0", out_d, fv_d, ov_d);
        end
    endtask

    task automatic test_static();
        apply_reset(18'h00005);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (fv_a !== (c == 4)) begin
                n_fail++; $display("FAIL static_valid_cycle%0d: got %b expected %b", c, fv_a, (c == 4));
            end
        end
        exp_f = '0;
        exp_f[0] = 16'h8000;
        exp_f[2] = 16'h8000;
        n_tests++;
        if (out_a !== exp_f) begin
            n_fail++; $display("FAIL static_frame: got %h expected %h", out_a, exp_f);
        end
        n_tests++;
        if (ov_a !== 1'b0) begin
            n_fail++; $display("FAIL static_overrun: got %b expected 0", ov_a);
        end
    endtask

    task automatic test_ramp();
        apply_reset(18'h1FFFF);
        for (int k = 0; k <= 16; k++) begin
            wait_frame(1'b0, ok);
            for (int i = 0; i < 16; i++) exp_f[i] = 16'(k * 256 + i * 4096);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL ramp_frame%0d: got no frame expected frame_valid", k);
            end else if (out_a !== exp_f) begin
                n_fail++; $display("FAIL ramp_frame%0d: got %h expected %h", k, out_a, exp_f);
            end
        end
    endtask

    task automatic test_decay();
        decay_seq[0] = 16'hFFFF; decay_seq[1] = 16'hBFFF; decay_seq[2] = 16'h7FFF;
        decay_seq[3] = 16'h3FFF; decay_seq[4] = 16'h0000; decay_seq[5] = 16'h0000;
        apply_reset(18'h20003);
        for (int k = 0; k <= 5; k++) begin
            wait_frame(1'b1, ok);
            exp_f    = '0;
            exp_f[0] = 16'hFFFF;
            exp_f[1] = decay_seq[k];
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL decay_frame%0d: got no frame expected frame_valid", k);
            end else if (out_d !== exp_f) begin
                n_fail++; $display("FAIL decay_frame%0d: got %h expected %h", k, out_d, exp_f);
            end
            if (k == 0) switches = 18'h20001;
        end
    endtask

    task automatic test_walk();
        apply_reset(18'h3000F);
        for (int k = 0; k <= 16; k++) begin
            wait_frame(1'b0, ok);
            exp_f = '0;
            if ((k % 16) < 4) exp_f[k % 16] = 16'hFFFF;
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL walk_frame%0d: got no frame expected frame_valid", k);
            end else if (out_a !== exp_f) begin
                n_fail++; $display("FAIL walk_frame%0d: got %h expected %h", k, out_a, exp_f);
            end
        end
        // Interrupt the walk with a static frame, then resume.
        switches = 18'h0000F;
        wait_frame(1'b0, ok);
        exp_f = '0;
        for (int i = 0; i < 4; i++) exp_f[i] = 16'h8000;
        n_tests++;
        if (!ok || out_a !== exp_f) begin
            n_fail++; $display("FAIL walk_to_static: got %h (valid seen %b) expected %h", out_a, ok, exp_f);
        end
        switches = 18'h3000F;
        wait_frame(1'b0, ok);
        exp_f = '0;
        exp_f[0] = 16'hFFFF;
        n_tests++;
        if (!ok || out_a !== exp_f) begin
            n_fail++; $display("FAIL walk_restart: got %h (valid seen %b) expected %h", out_a, ok, exp_f);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(18'h1FFFF);
        wait_frame(1'b0, ok);
        wait_frame(1'b0, ok);
        for (int i = 0; i < 16; i++) exp_f[i] = 16'(256 + i * 4096);
        n_tests++;
        if (!ok || out_a !== exp_f || ov_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_before: got %h ov=%b expected %h ov=0", out_a, ov_a, exp_f);
        end
        frame_ready = 1'b0;
        repeat (13) @(negedge clk);
        n_tests++;
        if (fv_a !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid_held: got %b expected 1", fv_a);
        end
        n_tests++;
        if (out_a !== exp_f) begin
            n_fail++; $display("FAIL bp_frame_held: got %h expected %h", out_a, exp_f);
        end
        n_tests++;
        if (ov_a !== 1'b1) begin
            n_fail++; $display("FAIL bp_overrun: got %b expected 1", ov_a);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (fv_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: got valid %b expected 0", fv_a);
        end
        wait_frame(1'b0, ok);
        for (int i = 0; i < 16; i++) exp_f[i] = 16'(512 + i * 4096);
        n_tests++;
        if (!ok || out_a !== exp_f) begin
            n_fail++; $display("FAIL bp_next_frame: got %h (valid seen %b) expected %h", out_a, ok, exp_f);
        end
        n_tests++;
        if (ov_a !== 1'b1) begin
            n_fail++; $display("FAIL bp_overrun_sticky: got %b expected 1", ov_a);
        end
    endtask

    task automatic test_async_reset();
        // Entered at a negedge with a ramp frame valid and overrun set.
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_a !== '0) begin
            n_fail++; $display("FAIL async_out: got %h expected 0", out_a);
        end
        n_tests++;
        if (fv_a !== 1'b0) begin
            n_fail++; $display("FAIL async_valid: got %b expected 0", fv_a);
        end
        n_tests++;
        if (ov_a !== 1'b0) begin
            n_fail++; $display("FAIL async_overrun: got %b expected 0", ov_a);
        end
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_frame(1'b0, ok);
        for (int i = 0; i < 16; i++) exp_f[i] = 16'(i * 4096);
        n_tests++;
        if (!ok || out_a !== exp_f) begin
            n_fail++; $display("FAIL async_first_frame: got %h (valid seen %b) expected %h", out_a, ok, exp_f);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        switches    = '0;
        frame_ready = 1'b1;
        test_reset();
        test_static();
        test_ramp();
        test_decay();
        test_walk();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
